// File: rtl/button_press_decoder.sv
// Turns the debounced active-low button level into single-cycle press, short,
// long, repeat and release events. After reset it ignores the button until it sees a release.
module button_press_decoder #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter bit REPEAT_EN   = 1'b1,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n,
  output logic pressed,
  output logic press_evt,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic release_evt
);

  localparam logic [1:0] ST_WAIT_REL = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_LONG     = 2'd3;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             pressed_s;
  logic             press_evt_s;
  logic             short_press_s;
  logic             long_press_s;
  logic             repeat_evt_s;
  logic             release_evt_s;

  // Next-state, hold counter and event decode; a release outranks timer expiry.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    pressed_s     = pressed;
    press_evt_s   = 1'b0;
    short_press_s = 1'b0;
    long_press_s  = 1'b0;
    repeat_evt_s  = 1'b0;
    release_evt_s = 1'b0;
    case (state_r)
      ST_WAIT_REL: begin
        pressed_s = 1'b0;
        if (button_n) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_REL;
        end
      end
      ST_IDLE: begin
        if (!button_n) begin
          state_s     = ST_PRESSED;
          cnt_s       = '0;
          pressed_s   = 1'b1;
          press_evt_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
          pressed_s = 1'b0;
        end
      end
      ST_PRESSED: begin
        if (button_n) begin
          state_s       = ST_IDLE;
          pressed_s     = 1'b0;
          short_press_s = 1'b1;
          release_evt_s = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          state_s      = ST_LONG;
          long_press_s = 1'b1;
          cnt_s        = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (button_n) begin
          state_s       = ST_IDLE;
          pressed_s     = 1'b0;
          release_evt_s = 1'b1;
        end else if (cnt_r == REP_LAST) begin
          // Without repeats the counter parks here instead of wrapping.
          if (REPEAT_EN) begin
            repeat_evt_s = 1'b1;
            cnt_s        = '0;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_WAIT_REL;
        cnt_s     = '0;
        pressed_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_WAIT_REL;
      cnt_r       <= '0;
      pressed     <= 1'b0;
      press_evt   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pressed     <= pressed_s;
      press_evt   <= press_evt_s;
      short_press <= short_press_s;
      long_press  <= long_press_s;
      repeat_evt  <= repeat_evt_s;
      release_evt <= release_evt_s;
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: a repeat-enabled and a repeat-disabled
// instance driven by the same button, checked against tables and a hold-time model.
module tb_button_press_decoder;

  localparam int LT = 8;
  localparam int RT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic button_n = 1'b0;

  logic pr1, pe1, sp1, lp1, re1, rl1;
  logic pr2, pe2, sp2, lp2, re2, rl2;

  button_press_decoder #(.LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .button_n(button_n),
    .pressed(pr1), .press_evt(pe1), .short_press(sp1),
    .long_press(lp1), .repeat_evt(re1), .release_evt(rl1)
  );

  button_press_decoder #(.LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .button_n(button_n),
    .pressed(pr2), .press_evt(pe2), .short_press(sp2),
    .long_press(lp2), .repeat_evt(re2), .release_evt(rl2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks how many edges the button has been held.
  bit m_armed, m_active, m_long;
  int m_hold;
  logic [5:0] exp1, exp2;   // {pressed, press, short, long, repeat, release}

  int long_cnt1, rep_cnt1, short_cnt1, rel_cnt1;
  int long_cnt2, rep_cnt2, rel_cnt2;

  typedef struct {
    logic       b;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [5:0] act1();
    return {pr1, pe1, sp1, lp1, re1, rl1};
  endfunction

  function automatic logic [5:0] act2();
    return {pr2, pe2, sp2, lp2, re2, rl2};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_active = 1'b0; m_long = 1'b0; m_hold = 0;
    exp1 = 6'b0; exp2 = 6'b0;
  endtask

  task automatic model_step(input logic b);
    logic pe, sp, lp, rep, rl;
    pe = 1'b0; sp = 1'b0; lp = 1'b0; rep = 1'b0; rl = 1'b0;
    if (!m_armed) begin
      m_armed = b;
    end else if (!m_active) begin
      if (!b) begin
        m_active = 1'b1; m_hold = 0; m_long = 1'b0; pe = 1'b1;
      end
    end else if (b) begin
      m_active = 1'b0; rl = 1'b1; sp = !m_long;
    end else begin
      m_hold++;
      if (m_hold == LT) begin
        m_long = 1'b1; lp = 1'b1;
      end else if (m_hold > LT && (m_hold - LT) % RT == 0) begin
        rep = 1'b1;
      end
    end
    exp1 = {m_active, pe, sp, lp, rep, rl};
    exp2 = {m_active, pe, sp, lp, 1'b0, rl};
  endtask

  task automatic tick(input logic b, input string name);
    button_n = b;
    @(posedge clk);
    model_step(b);
    #1;
    check({name, "/rep_on"}, act1(), exp1);
    check({name, "/rep_off"}, act2(), exp2);
    long_cnt1 += int'(lp1); rep_cnt1 += int'(re1); short_cnt1 += int'(sp1); rel_cnt1 += int'(rl1);
    long_cnt2 += int'(lp2); rep_cnt2 += int'(re2); rel_cnt2 += int'(rl2);
  endtask

  task automatic clear_counts();
    long_cnt1 = 0; rep_cnt1 = 0; short_cnt1 = 0; rel_cnt1 = 0;
    long_cnt2 = 0; rep_cnt2 = 0; rel_cnt2 = 0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 6'b000000};
    vecs[1]  = '{1'b0, 6'b000000};
    vecs[2]  = '{1'b1, 6'b000000};
    vecs[3]  = '{1'b0, 6'b110000};
    vecs[4]  = '{1'b0, 6'b100000};
    vecs[5]  = '{1'b0, 6'b100000};
    vecs[6]  = '{1'b1, 6'b001001};
    vecs[7]  = '{1'b1, 6'b000000};
    vecs[8]  = '{1'b0, 6'b110000};
    vecs[9]  = '{1'b1, 6'b001001};
    vecs[10] = '{1'b0, 6'b110000};
    vecs[11] = '{1'b1, 6'b001001};

    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state/rep_on", act1(), 6'b0);
    check("reset_state/rep_off", act2(), 6'b0);
    reset_n = 1'b1;

    // Button still low out of reset: nothing may happen.
    for (int i = 0; i < 20; i++) tick(1'b0, "held_from_reset");

    // Table: arm, short presses, press right after release.
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].b, "table_model");
      check($sformatf("table_%0d/rep_on", i), act1(), vecs[i].exp);
      check($sformatf("table_%0d/rep_off", i), act2(), vecs[i].exp);
    end

    // Release on the edge where the timer would expire.
    tick(1'b1, "idle_gap");
    clear_counts();
    tick(1'b0, "edge_press");
    for (int i = 0; i < LT - 1; i++) tick(1'b0, "edge_hold");
    tick(1'b1, "edge_release");
    check("edge_release_short", {5'b0, sp1}, 6'b000001);
    check_int("edge_no_long", long_cnt1 + long_cnt2, 0);

    // Long hold with repeats, then release.
    tick(1'b1, "idle_gap2");
    clear_counts();
    tick(1'b0, "long_press_start");
    for (int i = 0; i < LT + 3 * RT + 2; i++) tick(1'b0, "long_hold");
    tick(1'b1, "long_release");
    check_int("long_count_rep_on", long_cnt1, 1);
    check_int("repeat_count_rep_on", rep_cnt1, 3);
    check_int("short_count_long", short_cnt1, 0);
    check_int("release_count_rep_on", rel_cnt1, 1);
    check_int("long_count_rep_off", long_cnt2, 1);
    check_int("repeat_count_rep_off", rep_cnt2, 0);

    // 40-cycle hold: repeat-disabled counter must park, never repeat.
    clear_counts();
    tick(1'b0, "hold40_start");
    for (int i = 0; i < 40; i++) tick(1'b0, "hold40");
    tick(1'b1, "hold40_release");
    check_int("hold40_long_rep_off", long_cnt2, 1);
    check_int("hold40_repeat_rep_off", rep_cnt2, 0);
    check_int("hold40_release_rep_off", rel_cnt2, 1);

    // Asynchronous reset while in LONG.
    tick(1'b0, "rst_press");
    for (int i = 0; i < LT + 2; i++) tick(1'b0, "rst_hold");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset/rep_on", act1(), 6'b0);
    check("async_reset/rep_off", act2(), 6'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, "post_reset_low");
    tick(1'b1, "post_reset_release");
    tick(1'b0, "post_reset_press");
    check("post_reset_press_evt", {5'b0, pe1}, 6'b000001);
    tick(1'b1, "post_reset_rel");

    // Random press/release runs against the model.
    for (int k = 0; k < 80; k++) begin
      int plen, rlen;
      plen = $urandom_range(1, 30);
      rlen = $urandom_range(1, 4);
      for (int i = 0; i < plen; i++) tick(1'b0, "rand_press");
      for (int i = 0; i < rlen; i++) tick(1'b1, "rand_release");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
